four_bit_subtractor: RTL and testbench
======================================

// Module: four_bit_subtractor
//
// PURPOSE
// - WIDTH-bit (default 4) ripple-borrow subtractor: computes x - y - borrowIn.
// - Returns a difference and a borrow-out; chains with neighbours via borrowIn/borrowOut.
// - The combinational result is the primary output.
// - A one-cycle registered copy with a valid strobe serves clocked consumers in the datapath.
//
// PARAMETERS
// - WIDTH  4  operand / difference width in bits; must be >= 1
//
// PORTS
// - clk         in   1      system clock; all registers capture on the rising edge
// - reset       in   1      asynchronous, active-high reset
// - x           in   WIDTH  minuend
// - y           in   WIDTH  subtrahend
// - borrowIn    in   1      borrow into bit 0
// - validIn     in   1      capture strobe for the registered outputs
// - xy          out  WIDTH  combinational difference
// - borrowOut   out  1      combinational borrow out of the MSB
// - xyReg       out  WIDTH  registered difference
// - borrowReg   out  1      registered borrow-out
// - validOut    out  1      registered outputs updated on the previous edge
// - zero        out  1      FLAGS only: registered result == 0
// - overflow    out  1      FLAGS only: registered signed overflow
//
// BEHAVIOUR
// - Arithmetic: {borrowOut, xy} = ({1'b0,x} - {1'b0,y} - borrowIn) mod 2^(WIDTH+1).
//   - borrowOut = 1 exactly when x < y + borrowIn (unsigned).
// - Structure: WIDTH full-subtractor cells, with b0 = borrowIn and borrowOut = bWIDTH:
//   - d_i = x_i ^ y_i ^ b_i
//   - b_(i+1) = (~x_i & y_i) | (~(x_i ^ y_i) & b_i)
// - Combinational path: no clock involvement.
//   - xy/borrowOut must settle within 5 ns of any input change.
//   - No latches; all inputs in the sensitivity list.
// - Registered path (latency 1):
//   - Edge with validIn = 1: xyReg <= xy, borrowReg <= borrowOut, validOut <= 1.
//   - Edge with validIn = 0: xyReg/borrowReg hold their values; validOut <= 0.
// - Reset (asynchronous, active-high):
//   - xyReg = 0, borrowReg = 0, validOut = 0 immediately while reset = 1.
//   - zero = 0 and overflow = 0 when FLAGS are built.
//   - Combinational outputs are unaffected by reset.
//   - Reset asserted mid-operation discards any pending capture.
//   - First capture occurs on the first rising edge after reset deasserts with validIn = 1.
// - Boundaries:
//   - All-zero operands with borrowIn = 1 wrap to xy = all-ones, borrowOut = 1.
//   - x == y with borrowIn = 0 gives xy = 0, borrowOut = 0.
//   - No saturation; results always wrap.
//
// CONFIGURATION
// - Macro FOUR_BIT_SUBTRACTOR_FLAGS_EN.
// - Defined: zero and overflow ports exist; both update together with xyReg.
//   - zero = (next xyReg == 0).
//   - overflow = (x[MSB] != y[MSB]) && (xy[MSB] != x[MSB]); borrowIn is included in xy.
// - Undefined: zero and overflow ports and their logic are absent.
//   - All other behaviour is identical.
//
// TESTING
// - Exhaustive sweep: all 2^(2*WIDTH+1) {x,y,borrowIn} combinations, 5 ns apart.
//   - Required: {borrowOut,xy} == x - y - borrowIn (5-bit) for all 512 when WIDTH = 4.
// - x=9, y=3, bIn=0 -> xy=6, borrowOut=0; x=3, y=5, bIn=0 -> xy=E, borrowOut=1.
// - x=0, y=0, bIn=1 -> xy=F, borrowOut=1; x=F, y=F, bIn=1 -> xy=F, borrowOut=1.
// - validIn=1 with x=7, y=2:
//   - Next edge: xyReg=5, borrowReg=0, validOut=1.
//   - Following edge with validIn=0: validOut=0, xyReg stays 5.
// - Assert reset between edges -> xyReg, borrowReg, validOut drop to 0 without a clock edge.
// - FLAGS_EN, captured: x=8, y=1, bIn=0 -> xyReg=7, overflow=1, zero=0.
// - FLAGS_EN, captured: x=4, y=4, bIn=0 -> xyReg=0, zero=1, overflow=0.

Source files
------------

// File: rtl/four_bit_subtractor_if.sv
// Operand/result bundle for four_bit_subtractor; flag signals exist only
// when FOUR_BIT_SUBTRACTOR_FLAGS_EN is defined.
interface four_bit_subtractor_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             borrowIn;
  logic             validIn;
  logic [WIDTH-1:0] xy;
  logic             borrowOut;
  logic [WIDTH-1:0] xyReg;
  logic             borrowReg;
  logic             validOut;
`ifdef FOUR_BIT_SUBTRACTOR_FLAGS_EN
  logic             zero;
  logic             overflow;

  modport master (
    output x, y, borrowIn, validIn,
    input  xy, borrowOut, xyReg, borrowReg, validOut, zero, overflow
  );
  modport slave (
    input  x, y, borrowIn, validIn,
    output xy, borrowOut, xyReg, borrowReg, validOut, zero, overflow
  );
`else
  modport master (
    output x, y, borrowIn, validIn,
    input  xy, borrowOut, xyReg, borrowReg, validOut
  );
  modport slave (
    input  x, y, borrowIn, validIn,
    output xy, borrowOut, xyReg, borrowReg, validOut
  );
`endif
endinterface

// File: rtl/four_bit_subtractor.sv
// Ripple-borrow subtractor x - y - borrowIn with a one-cycle registered copy.
// Optional zero/overflow flags: define FOUR_BIT_SUBTRACTOR_FLAGS_EN.
module four_bit_subtractor #(
  parameter int unsigned WIDTH = 4
) (
  input logic                 clk,
  input logic                 reset,
  four_bit_subtractor_if.slave bus
);
  localparam int unsigned MSB = WIDTH - 1;

  logic [WIDTH-1:0] diff;
  logic             borrow;

  // Full-subtractor chain; the running borrow is a procedural variable.
  always_comb begin
    logic b;
    diff = '0;
    b    = bus.borrowIn;
    for (int i = 0; i < int'(WIDTH); i++) begin
      diff[i] = bus.x[i] ^ bus.y[i] ^ b;
      b       = (~bus.x[i] & bus.y[i]) | (~(bus.x[i] ^ bus.y[i]) & b);
    end
    borrow = b;
  end

  assign bus.xy        = diff;
  assign bus.borrowOut = borrow;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.xyReg     <= '0;
      bus.borrowReg <= 1'b0;
      bus.validOut  <= 1'b0;
    end else if (bus.validIn) begin
      bus.xyReg     <= diff;
      bus.borrowReg <= borrow;
      bus.validOut  <= 1'b1;
    end else begin
      bus.validOut  <= 1'b0;
    end
  end

`ifdef FOUR_BIT_SUBTRACTOR_FLAGS_EN
  logic zeroNext;
  logic overflowNext;

  // Signed overflow: operand signs differ and the result sign departs from x.
  assign zeroNext     = (diff == '0);
  assign overflowNext = (bus.x[MSB] != bus.y[MSB]) && (diff[MSB] != bus.x[MSB]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.zero     <= 1'b0;
      bus.overflow <= 1'b0;
    end else if (bus.validIn) begin
      bus.zero     <= zeroNext;
      bus.overflow <= overflowNext;
    end
  end
`endif
endmodule

// File: tb/tb_four_bit_subtractor.sv
// Directed and exhaustive checks for four_bit_subtractor (WIDTH = 4).
module tb_four_bit_subtractor;
  localparam int unsigned WIDTH = 4;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  four_bit_subtractor_if #(.WIDTH(WIDTH)) bus ();

  four_bit_subtractor #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic combVec(input logic [3:0] a, input logic [3:0] b, input logic bi,
                         input logic [3:0] expXy, input logic expB, input string tag);
    bus.x = a; bus.y = b; bus.borrowIn = bi;
    #4;
    check({tag, "_xy"}, 32'(bus.xy), 32'(expXy));
    check({tag, "_bo"}, 32'(bus.borrowOut), 32'(expB));
    #1;
  endtask

  task automatic checkRegs(input logic [3:0] expXy, input logic expB, input logic expV,
                           input string tag);
    check({tag, "_xyReg"}, 32'(bus.xyReg), 32'(expXy));
    check({tag, "_borrowReg"}, 32'(bus.borrowReg), 32'(expB));
    check({tag, "_validOut"}, 32'(bus.validOut), 32'(expV));
  endtask

  initial begin
    logic [4:0] expect5;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.x = '0; bus.y = '0; bus.borrowIn = 1'b0; bus.validIn = 1'b0;

    // Reset state before any clock edge
    #1 reset = 1'b1;
    #2;
    checkRegs(4'h0, 1'b0, 1'b0, "reset");
`ifdef FOUR_BIT_SUBTRACTOR_FLAGS_EN
    check("reset_zero", 32'(bus.zero), 32'd0);
    check("reset_overflow", 32'(bus.overflow), 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // Directed combinational vectors
    combVec(4'h9, 4'h3, 1'b0, 4'h6, 1'b0, "v9m3");
    combVec(4'h3, 4'h5, 1'b0, 4'hE, 1'b1, "v3m5");
    combVec(4'h0, 4'h0, 1'b1, 4'hF, 1'b1, "v0m0b");
    combVec(4'hF, 4'hF, 1'b1, 4'hF, 1'b1, "vFmFb");
    combVec(4'hA, 4'hA, 1'b0, 4'h0, 1'b0, "vAmA");
    combVec(4'h0, 4'h1, 1'b0, 4'hF, 1'b1, "v0m1");

    // Exhaustive sweep, 5 ns apart
    for (int i = 0; i < 512; i++) begin
      bus.x        = 4'(i >> 5);
      bus.y        = 4'(i >> 1);
      bus.borrowIn = i[0];
      #4;
      expect5 = 5'({1'b0, bus.x} - {1'b0, bus.y} - {4'b0, bus.borrowIn});
      check("sweep", 32'({bus.borrowOut, bus.xy}), 32'(expect5));
      #1;
    end

    // Registered capture then hold
    @(negedge clk);
    bus.x = 4'h7; bus.y = 4'h2; bus.borrowIn = 1'b0; bus.validIn = 1'b1;
    @(posedge clk); #1;
    checkRegs(4'h5, 1'b0, 1'b1, "cap72");
    @(negedge clk);
    bus.validIn = 1'b0; bus.x = 4'h1; bus.y = 4'h2;
    @(posedge clk); #1;
    checkRegs(4'h5, 1'b0, 1'b0, "hold");

    // Asynchronous reset between edges
    @(negedge clk);
    bus.x = 4'h9; bus.y = 4'h3; bus.validIn = 1'b1;
    @(posedge clk); #1;
    checkRegs(4'h6, 1'b0, 1'b1, "cap93");
    #2 reset = 1'b1;
    #1;
    checkRegs(4'h0, 1'b0, 1'b0, "asyncRst");
    check("rst_comb_xy", 32'(bus.xy), 32'h6);
    @(posedge clk); #1;
    checkRegs(4'h0, 1'b0, 1'b0, "rstHeld");
    @(negedge clk);
    reset = 1'b0;
    bus.x = 4'h3; bus.y = 4'h5;
    @(posedge clk); #1;
    checkRegs(4'hE, 1'b1, 1'b1, "firstCap");

`ifdef FOUR_BIT_SUBTRACTOR_FLAGS_EN
    @(negedge clk);
    bus.x = 4'h8; bus.y = 4'h1; bus.borrowIn = 1'b0; bus.validIn = 1'b1;
    @(posedge clk); #1;
    check("f81_xyReg", 32'(bus.xyReg), 32'h7);
    check("f81_overflow", 32'(bus.overflow), 32'd1);
    check("f81_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    bus.x = 4'h4; bus.y = 4'h4;
    @(posedge clk); #1;
    check("f44_xyReg", 32'(bus.xyReg), 32'h0);
    check("f44_zero", 32'(bus.zero), 32'd1);
    check("f44_overflow", 32'(bus.overflow), 32'd0);
`endif

    @(negedge clk);
    bus.validIn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
